mem_bus_arbiter: RTL and testbench

//  Shares the single 6502 memory bus between instruction prefetch (IF) and execute data access (DX).

---
 rtl/mem_bus_arbiter_pkg.sv | 22 ++
 rtl/mem_bus_arbiter_pick.sv | 48 ++++
 rtl/mem_bus_arbiter.sv | 111 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the 6502 memory bus arbiter: FSM state codes,
// transfer owner codes, default bus widths and the grant-window helper.
package mem_bus_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  // FSM state codes
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  // Owner of the transfer currently on the bus
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DX = 1'b1;

  // A new request may be accepted when the bus is idle or the current
  // transfer is completing this cycle.
  function automatic logic in_grant_window(input logic state, input logic mem_ready);
    return (state == ST_IDLE) || mem_ready;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// bus_arb_pick: combinational winner select between IF and DX, with the
// optional IF starvation guard (enabled by defining ARB_STARVE_GUARD_EN).
module bus_arb_pick #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic window,
  input  logic if_req,
  input  logic if_flush,
  input  logic dx_req,
  output logic if_gnt,
  output logic dx_gnt
);

  logic force_if;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt;

  // IF wins the next grant once DX has been granted STARVE_MAX times in a row
  // while IF waited; a flushing IF cannot take a grant, so it does not force.
  assign force_if = (starve_cnt == CNT_W'(STARVE_MAX)) && if_req && !if_flush;

  // Count DX grants made while IF is waiting; clear on IF grant or no IF request
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (if_gnt || !if_req) begin
      starve_cnt <= '0;
    end else if (dx_gnt && (starve_cnt != CNT_W'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  logic unused_guard_inputs;
  assign unused_guard_inputs = clk ^ rst ^ (STARVE_MAX == 0);
  assign force_if = 1'b0;
`endif

  // DX has priority unless the starvation guard forces IF
  always_comb begin
    dx_gnt = window && dx_req && !force_if;
    if_gnt = window && if_req && !if_flush && (!dx_req || force_if);
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single 6502 memory bus between instruction
// prefetch (IF) and execute data access (DX). One transfer at a time, held
// through wait states; registered done strobes and read data per requester.
// Optional feature: define ARB_STARVE_GUARD_EN to bound consecutive DX grants
// while IF is waiting (STARVE_MAX).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dx_req,
  input  logic              dx_we,
  input  logic [ADDR_W-1:0] dx_addr,
  input  logic [DATA_W-1:0] dx_wdata,
  output logic              dx_gnt,
  output logic              dx_done,
  output logic [DATA_W-1:0] dx_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic state;
  logic owner;
  logic if_kill;     // IF transfer in flight was flushed; drop its done
  logic window;
  logic complete;
  logic if_deliver;

  assign window   = !rst && in_grant_window(state, mem_ready);
  assign complete = (state == ST_BUSY) && mem_ready;
  assign mem_en   = (state == ST_BUSY);

  // An IF completion is reported only if no flush hit it, including this cycle
  assign if_deliver = complete && (owner == OWN_IF) && !if_kill && !if_flush;

  bus_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk      (clk),
    .rst      (rst),
    .window   (window),
    .if_req   (if_req),
    .if_flush (if_flush),
    .dx_req   (dx_req),
    .if_gnt   (if_gnt),
    .dx_gnt   (dx_gnt)
  );

  // FSM, bus registers, done strobes and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      if_kill   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      dx_done   <= 1'b0;
      if_rdata  <= '0;
      dx_rdata  <= '0;
    end else begin
      if_done <= if_deliver;
      dx_done <= complete && (owner == OWN_DX);
      if (if_deliver) begin
        if_rdata <= mem_rdata;
      end
      if (complete && (owner == OWN_DX) && !mem_we) begin
        dx_rdata <= mem_rdata;
      end

      if (dx_gnt) begin
        state     <= ST_BUSY;
        owner     <= OWN_DX;
        if_kill   <= 1'b0;
        mem_we    <= dx_we;
        mem_addr  <= dx_addr;
        mem_wdata <= dx_wdata;
      end else if (if_gnt) begin
        state    <= ST_BUSY;
        owner    <= OWN_IF;
        if_kill  <= 1'b0;
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
      end else begin
        if (complete) begin
          state  <= ST_IDLE;
          mem_we <= 1'b0;
        end
        if ((state == ST_BUSY) && (owner == OWN_IF) && if_flush) begin
          if_kill <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vectors, scoreboard
// queues of expected read data per requester, decoupled done monitor.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, dx_req, dx_we, mem_ready;
  logic [15:0] if_addr, dx_addr;
  logic [7:0]  dx_wdata, mem_rdata;
  logic        if_gnt, if_done, dx_gnt, dx_done, mem_en, mem_we;
  logic [7:0]  if_rdata, dx_rdata, mem_wdata;
  logic [15:0] mem_addr;

  int checks   = 0;
  int failures = 0;

  logic [7:0] if_q[$];
  logic [7:0] dx_q[$];

  mem_bus_arbiter #(
    .ADDR_W     (16),
    .DATA_W     (8),
    .STARVE_MAX (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_gnt    (if_gnt),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .dx_req    (dx_req),
    .dx_we     (dx_we),
    .dx_addr   (dx_addr),
    .dx_wdata  (dx_wdata),
    .dx_gnt    (dx_gnt),
    .dx_done   (dx_done),
    .dx_rdata  (dx_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Monitor: every done strobe pops the matching expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (if_done) begin
        if (if_q.size() == 0) chk("unexpected_if_done", 32'd1, 32'd0);
        else chk("if_rdata", {24'd0, if_rdata}, {24'd0, if_q.pop_front()});
      end
      if (dx_done) begin
        if (dx_q.size() == 0) chk("unexpected_dx_done", 32'd1, 32'd0);
        else chk("dx_rdata", {24'd0, dx_rdata}, {24'd0, dx_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_dx;
    rst = 1'b1; if_req = 0; if_flush = 0; dx_req = 0; dx_we = 0; mem_ready = 0;
    if_addr = '0; dx_addr = '0; dx_wdata = '0; mem_rdata = '0;
    repeat (2) tick();
    sample();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_dones", {if_done, dx_done}, 0);
    chk("rst_rdata", {if_rdata, dx_rdata}, 0);
    tick(); rst = 1'b0;

    // T1: single IF read, no waits
    if_req = 1; if_addr = 16'hC000; mem_ready = 1; mem_rdata = 8'hA9;
    sample();
    chk("t1_if_gnt", if_gnt, 1);
    chk("t1_dx_gnt", dx_gnt, 0);
    chk("t1_mem_en_n", mem_en, 0);
    if_q.push_back(8'hA9);
    tick(); if_req = 0;
    sample();
    chk("t1_mem_en", mem_en, 1);
    chk("t1_mem_addr", mem_addr, 16'hC000);
    chk("t1_mem_we", mem_we, 0);
    tick(); sample();
    chk("t1_if_done", if_done, 1);
    chk("t1_mem_en_idle", mem_en, 0);

    // T2: DX beats IF, IF granted in DX completion cycle
    tick();
    if_req = 1; if_addr = 16'h1234; dx_req = 1; dx_we = 0; dx_addr = 16'h0200; mem_rdata = 8'h3C;
    sample();
    chk("t2_dx_gnt", dx_gnt, 1);
    chk("t2_if_gnt_lose", if_gnt, 0);
    dx_q.push_back(8'h3C);
    tick(); dx_req = 0;
    sample();
    chk("t2_if_gnt_b2b", if_gnt, 1);
    chk("t2_mem_en1", mem_en, 1);
    chk("t2_mem_addr1", mem_addr, 16'h0200);
    if_q.push_back(8'h77);
    tick(); if_req = 0; mem_rdata = 8'h77;
    sample();
    chk("t2_mem_en2", mem_en, 1);
    chk("t2_mem_addr2", mem_addr, 16'h1234);
    chk("t2_dx_done", dx_done, 1);
    tick(); mem_ready = 0;
    sample();
    chk("t2_mem_en_off", mem_en, 0);
    chk("t2_if_done", if_done, 1);

    // T3: DX write with three wait states
    tick();
    dx_req = 1; dx_we = 1; dx_addr = 16'h01FF; dx_wdata = 8'h5A; mem_rdata = 8'hFF;
    sample();
    chk("t3_dx_gnt", dx_gnt, 1);
    dx_q.push_back(8'h3C);
    tick(); dx_req = 0; dx_we = 0; dx_wdata = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1;
      sample();
      chk("t3_mem_en", mem_en, 1);
      chk("t3_mem_we", mem_we, 1);
      chk("t3_mem_addr", mem_addr, 16'h01FF);
      chk("t3_mem_wdata", mem_wdata, 8'h5A);
      tick();
    end
    mem_ready = 0;
    sample();
    chk("t3_mem_en_off", mem_en, 0);
    chk("t3_dx_done", dx_done, 1);

    // T4: flushed IF read, then a normal IF read
    tick(); if_req = 1; if_addr = 16'h8000;
    sample();
    chk("t4_if_gnt", if_gnt, 1);
    tick(); if_req = 0; if_flush = 1;
    sample();
    chk("t4_busy", mem_en, 1);
    tick(); if_flush = 0;
    sample();
    tick(); mem_ready = 1; mem_rdata = 8'hEE; if_req = 1; if_addr = 16'h8002; if_flush = 1;
    sample();
    chk("t4_flush_blocks_gnt", if_gnt, 0);
    tick(); if_flush = 0; mem_rdata = 8'h42;
    sample();
    chk("t4_if_done_suppressed", if_done, 0);
    chk("t4_mem_en_idle", mem_en, 0);
    chk("t4_if_gnt2", if_gnt, 1);
    if_q.push_back(8'h42);
    tick(); if_req = 0;
    sample();
    chk("t4_mem_addr2", mem_addr, 16'h8002);
    tick(); sample();
    chk("t4_if_done2", if_done, 1);

    // T5: both requesters held high
    tick();
    dx_req = 1; dx_we = 0; dx_addr = 16'h0300; if_req = 1; if_addr = 16'h9000; mem_rdata = 8'h11;
    for (int k = 0; k < 10; k++) begin
      sample();
`ifdef ARB_STARVE_GUARD_EN
      exp_dx = ((k % 5) != 4);
`else
      exp_dx = 1'b1;
`endif
      chk("t5_dx_gnt", dx_gnt, exp_dx);
      chk("t5_if_gnt", if_gnt, !exp_dx);
      if (exp_dx) dx_q.push_back(8'h11);
      else if_q.push_back(8'h11);
      tick();
    end
    dx_req = 0; if_req = 0;
    sample();
    chk("t5_last_busy", mem_en, 1);
    tick(); sample();
    chk("t5_mem_en_off", mem_en, 0);

    // T6: reset mid-transfer
    tick(); dx_req = 1; dx_addr = 16'h0400; mem_ready = 0; mem_rdata = 8'h99;
    sample();
    chk("t6_dx_gnt", dx_gnt, 1);
    tick(); dx_req = 0; rst = 1;
    sample();
    chk("t6_busy", mem_en, 1);
    tick(); rst = 0; mem_ready = 1;
    sample();
    chk("t6_mem_en", mem_en, 0);
    chk("t6_mem_addr", mem_addr, 0);
    chk("t6_dx_rdata", dx_rdata, 0);
    chk("t6_dx_done", dx_done, 0);
    tick(); sample();
    chk("t6_no_done", {if_done, dx_done}, 0);
    chk("t6_idle", mem_en, 0);

    repeat (3) tick();
    chk("if_q_drained", if_q.size(), 0);
    chk("dx_q_drained", dx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
